// File: rtl/traffic_ctrl_n.sv
// traffic_ctrl_n: N-approach traffic-light controller.
// One approach owns the intersection at a time. Its green time scales with the
// number of occupied lanes. Every change of owner passes through yellow and an
// optional all-red clearance. Emergency requests cut a running green short and
// steer the next owner.
module traffic_ctrl_n #(
  parameter int N_DIR  = 4,
  parameter int LANES  = 2,
  parameter int SLOT   = 15,
  parameter int YELLOW = 5,
  parameter int ALLRED = 2,
  parameter int CNT_W  = 8,
  parameter int DIR_W  = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_DIR*LANES-1:0]   sensors,
  input  logic [N_DIR-1:0]         emerg,
  output logic [3*N_DIR-1:0]       lights,
  output logic [DIR_W-1:0]         active_dir,
  output logic [1:0]               phase,
  output logic                     preempt
);

  typedef enum logic [1:0] {
    PH_GREEN  = 2'b00,
    PH_YELLOW = 2'b01,
    PH_ALLRED = 2'b10,
    PH_BAD    = 2'b11
  } phase_e;

  localparam logic [2:0]       LAMP_G   = 3'b001;
  localparam logic [2:0]       LAMP_Y   = 3'b010;
  localparam logic [2:0]       LAMP_R   = 3'b100;
  localparam logic [CNT_W-1:0] SLOT_C   = CNT_W'(SLOT);
  localparam logic [CNT_W-1:0] YELLOW_C = CNT_W'(YELLOW);
  localparam logic [CNT_W-1:0] ALLRED_C = CNT_W'(ALLRED);
  localparam logic [CNT_W-1:0] ONE_C    = CNT_W'(1);

  // Green duration for one approach: max(occupied lanes, 1) * SLOT.
  function automatic logic [CNT_W-1:0] gtime_f(input logic [LANES-1:0] lanes);
    logic [CNT_W-1:0] occ;
    occ = '0;
    for (int i = 0; i < LANES; i++) begin
      occ = occ + CNT_W'(lanes[i]);
    end
    if (occ == '0) begin
      occ = ONE_C;
    end
    return occ * SLOT_C;
  endfunction

  phase_e           phase_q, phase_d;
  logic [DIR_W-1:0] active_dir_q, active_dir_d;
  logic [DIR_W-1:0] target_dir_q, target_dir_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic             preempt_q;

  logic [N_DIR-1:0] req;
  logic [CNT_W-1:0] gtime [N_DIR];
  logic [DIR_W-1:0] em_dir;
  logic             em_any;
  logic [DIR_W-1:0] next_dir;
  logic             next_found;
  int               scan_best;
  int               scan_dist;

  // Per-approach request flag and green duration from the lane sensors.
  always_comb begin
    for (int d = 0; d < N_DIR; d++) begin
      req[d]   = |sensors[d*LANES +: LANES];
      gtime[d] = gtime_f(sensors[d*LANES +: LANES]);
    end
  end

  // Emergency priority encoder: the lowest requesting index wins.
  always_comb begin
    em_any = |emerg;
    em_dir = '0;
    for (int d = N_DIR - 1; d >= 0; d--) begin
      if (emerg[d]) begin
        em_dir = DIR_W'(d);
      end
    end
  end

  // Round-robin search for the nearest requesting approach after the owner.
  always_comb begin
    next_found = 1'b0;
    next_dir   = active_dir_q;
    scan_best  = N_DIR;
    scan_dist  = 0;
    for (int d = 0; d < N_DIR; d++) begin
      scan_dist = (d + N_DIR - int'(active_dir_q)) % N_DIR;
      if (req[d] && (scan_dist != 0) && (scan_dist < scan_best)) begin
        scan_best  = scan_dist;
        next_dir   = DIR_W'(d);
        next_found = 1'b1;
      end
    end
  end

  // Phase sequencing and timer: each phase loaded with T lasts exactly T cycles.
  always_comb begin
    phase_d      = phase_q;
    active_dir_d = active_dir_q;
    target_dir_d = target_dir_q;
    timer_d      = timer_q;
    case (phase_q)
      PH_GREEN: begin
        if (em_any && (em_dir == active_dir_q)) begin
          // Emergency is already on the green approach: hold it.
          timer_d = timer_q;
        end else if (em_any) begin
          phase_d      = PH_YELLOW;
          target_dir_d = em_dir;
          timer_d      = YELLOW_C;
        end else if (timer_q == ONE_C) begin
          if (next_found) begin
            phase_d      = PH_YELLOW;
            target_dir_d = next_dir;
            timer_d      = YELLOW_C;
          end else begin
            timer_d = gtime[active_dir_q];
          end
        end else begin
          timer_d = timer_q - ONE_C;
        end
      end
      PH_YELLOW: begin
        if (em_any) begin
          target_dir_d = em_dir;
        end
        if (timer_q == ONE_C) begin
          if (ALLRED > 0) begin
            phase_d = PH_ALLRED;
            timer_d = ALLRED_C;
          end else begin
            phase_d      = PH_GREEN;
            active_dir_d = target_dir_d;
            timer_d      = gtime[target_dir_d];
          end
        end else begin
          timer_d = timer_q - ONE_C;
        end
      end
      PH_ALLRED: begin
        if (em_any) begin
          target_dir_d = em_dir;
        end
        if (timer_q == ONE_C) begin
          phase_d      = PH_GREEN;
          active_dir_d = target_dir_d;
          timer_d      = gtime[target_dir_d];
        end else begin
          timer_d = timer_q - ONE_C;
        end
      end
      default: begin
        // Unreachable encoding: recover to the reset state.
        phase_d      = PH_GREEN;
        active_dir_d = '0;
        target_dir_d = '0;
        timer_d      = SLOT_C;
      end
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q      <= PH_GREEN;
      active_dir_q <= '0;
      target_dir_q <= '0;
      timer_q      <= SLOT_C;
      preempt_q    <= 1'b0;
    end else begin
      phase_q      <= phase_d;
      active_dir_q <= active_dir_d;
      target_dir_q <= target_dir_d;
      timer_q      <= timer_d;
      preempt_q    <= em_any;
    end
  end

  // Lamp decode from registered state only; non-owners are always red.
  always_comb begin
    lights = '0;
    for (int d = 0; d < N_DIR; d++) begin
      lights[3*d +: 3] = LAMP_R;
      if (DIR_W'(d) == active_dir_q) begin
        case (phase_q)
          PH_GREEN:  lights[3*d +: 3] = LAMP_G;
          PH_YELLOW: lights[3*d +: 3] = LAMP_Y;
          default:   lights[3*d +: 3] = LAMP_R;
        endcase
      end
    end
  end

  assign active_dir = active_dir_q;
  assign phase      = phase_q;
  assign preempt    = preempt_q;

endmodule

// File: tb/tb_traffic_ctrl_n.sv
// Directed testbench for traffic_ctrl_n (4 approaches, 2 lanes each).
// A second instance built without the all-red phase shares the inputs.
module tb_traffic_ctrl_n;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  sensors;
  logic [3:0]  emerg;
  logic [11:0] lights, lights_nr;
  logic [1:0]  active_dir, active_dir_nr;
  logic [1:0]  phase, phase_nr;
  logic        preempt, preempt_nr;

  int checks = 0;
  int errors = 0;

  localparam logic [11:0] ALL_RED = 12'b100_100_100_100;

  always #5 clk = ~clk;

  traffic_ctrl_n #(.N_DIR(4), .LANES(2), .SLOT(15), .YELLOW(5), .ALLRED(2),
                   .CNT_W(8), .DIR_W(2)) dut (
    .clk(clk), .rst(rst), .sensors(sensors), .emerg(emerg),
    .lights(lights), .active_dir(active_dir), .phase(phase), .preempt(preempt)
  );

  traffic_ctrl_n #(.N_DIR(4), .LANES(2), .SLOT(15), .YELLOW(5), .ALLRED(0),
                   .CNT_W(8), .DIR_W(2)) dut_nr (
    .clk(clk), .rst(rst), .sensors(sensors), .emerg(emerg),
    .lights(lights_nr), .active_dir(active_dir_nr), .phase(phase_nr), .preempt(preempt_nr)
  );

  // Expected lamp vector: every approach red except dir, which shows the
  // lamp for phase ph (all red when ph is all-red).
  function automatic logic [11:0] exp_lamps(input int dir, input logic [1:0] ph);
    logic [11:0] v;
    v = ALL_RED;
    if (ph == 2'b00) v[3*dir +: 3] = 3'b001;
    else if (ph == 2'b01) v[3*dir +: 3] = 3'b010;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench observing cycle 1 (the first cycle after the reset edge).
  task automatic do_reset(input logic [7:0] s);
    rst = 1'b1;
    sensors = s;
    emerg = 4'b0000;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset(8'b0000_0000);
    checks++;
    if (lights !== 12'b100_100_100_001) begin
      errors++; $display("FAIL reset_lights got=%b want=%b", lights, 12'b100_100_100_001);
    end
    checks++;
    if (active_dir !== 2'd0) begin
      errors++; $display("FAIL reset_dir got=%0d want=0", active_dir);
    end
    checks++;
    if (phase !== 2'b00) begin
      errors++; $display("FAIL reset_phase got=%b want=00", phase);
    end
    checks++;
    if (preempt !== 1'b0) begin
      errors++; $display("FAIL reset_preempt got=%b want=0", preempt);
    end
    checks++;
    if (lights_nr !== 12'b100_100_100_001) begin
      errors++; $display("FAIL reset_lights_nr got=%b want=%b", lights_nr, 12'b100_100_100_001);
    end
    for (int c = 1; c <= 50; c++) begin
      checks++;
      if (lights !== 12'b100_100_100_001 || phase !== 2'b00 || active_dir !== 2'd0) begin
        errors++;
        $display("FAIL idle c=%0d got lights=%b phase=%b dir=%0d want lights=100100100001 phase=00 dir=0",
                 c, lights, phase, active_dir);
      end
      tick();
    end
  endtask

  task automatic test_basic();
    logic [1:0] ep, ep_nr;
    int ed, ed_nr;
    do_reset(8'b0000_0100);
    for (int c = 1; c <= 40; c++) begin
      if (c <= 15)      begin ep = 2'b00; ed = 0; end
      else if (c <= 20) begin ep = 2'b01; ed = 0; end
      else if (c <= 22) begin ep = 2'b10; ed = 0; end
      else              begin ep = 2'b00; ed = 1; end
      if (c <= 15)      begin ep_nr = 2'b00; ed_nr = 0; end
      else if (c <= 20) begin ep_nr = 2'b01; ed_nr = 0; end
      else              begin ep_nr = 2'b00; ed_nr = 1; end
      checks++;
      if (phase !== ep || active_dir !== 2'(ed) || lights !== exp_lamps(ed, ep)) begin
        errors++;
        $display("FAIL basic c=%0d got ph=%b dir=%0d lights=%b want ph=%b dir=%0d lights=%b",
                 c, phase, active_dir, lights, ep, ed, exp_lamps(ed, ep));
      end
      checks++;
      if (phase_nr !== ep_nr || active_dir_nr !== 2'(ed_nr) || lights_nr !== exp_lamps(ed_nr, ep_nr)) begin
        errors++;
        $display("FAIL no_allred c=%0d got ph=%b dir=%0d lights=%b want ph=%b dir=%0d lights=%b",
                 c, phase_nr, active_dir_nr, lights_nr, ep_nr, ed_nr, exp_lamps(ed_nr, ep_nr));
      end
      tick();
    end
  endtask

  task automatic test_lane_scaling();
    logic [1:0] ep;
    int ed;
    do_reset(8'b0011_0000);
    for (int c = 1; c <= 58; c++) begin
      if (c <= 15)      begin ep = 2'b00; ed = 0; end
      else if (c <= 20) begin ep = 2'b01; ed = 0; end
      else if (c <= 22) begin ep = 2'b10; ed = 0; end
      else if (c <= 52) begin ep = 2'b00; ed = 2; end
      else if (c <= 57) begin ep = 2'b01; ed = 2; end
      else              begin ep = 2'b10; ed = 2; end
      checks++;
      if (phase !== ep || active_dir !== 2'(ed) || lights !== exp_lamps(ed, ep)) begin
        errors++;
        $display("FAIL lanes c=%0d got ph=%b dir=%0d lights=%b want ph=%b dir=%0d lights=%b",
                 c, phase, active_dir, lights, ep, ed, exp_lamps(ed, ep));
      end
      if (c == 30) sensors = 8'b0100_0000;
      tick();
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] ep;
    int ed;
    do_reset(8'b0000_0100);
    for (int c = 1; c <= 70; c++) begin
      if (c <= 15)      begin ep = 2'b00; ed = 0; end
      else if (c <= 20) begin ep = 2'b01; ed = 0; end
      else if (c <= 22) begin ep = 2'b10; ed = 0; end
      else if (c <= 37) begin ep = 2'b00; ed = 1; end
      else if (c <= 42) begin ep = 2'b01; ed = 1; end
      else if (c <= 44) begin ep = 2'b10; ed = 1; end
      else if (c <= 59) begin ep = 2'b00; ed = 3; end
      else if (c <= 64) begin ep = 2'b01; ed = 3; end
      else if (c <= 66) begin ep = 2'b10; ed = 3; end
      else              begin ep = 2'b00; ed = 0; end
      checks++;
      if (phase !== ep || active_dir !== 2'(ed) || lights !== exp_lamps(ed, ep)) begin
        errors++;
        $display("FAIL round_robin c=%0d got ph=%b dir=%0d lights=%b want ph=%b dir=%0d lights=%b",
                 c, phase, active_dir, lights, ep, ed, exp_lamps(ed, ep));
      end
      if (c == 23) sensors = 8'b0100_0001;
      tick();
    end
  endtask

  task automatic test_emergency();
    logic [1:0] ep;
    int ed;
    logic epre;
    do_reset(8'b0011_0001);
    for (int c = 1; c <= 92; c++) begin
      if (c <= 3)       begin ep = 2'b00; ed = 0; end
      else if (c <= 8)  begin ep = 2'b01; ed = 0; end
      else if (c <= 10) begin ep = 2'b10; ed = 0; end
      else if (c <= 89) begin ep = 2'b00; ed = 2; end
      else              begin ep = 2'b01; ed = 2; end
      epre = (c >= 4 && c <= 60);
      checks++;
      if (phase !== ep || active_dir !== 2'(ed) || lights !== exp_lamps(ed, ep)) begin
        errors++;
        $display("FAIL emergency c=%0d got ph=%b dir=%0d lights=%b want ph=%b dir=%0d lights=%b",
                 c, phase, active_dir, lights, ep, ed, exp_lamps(ed, ep));
      end
      checks++;
      if (preempt !== epre) begin
        errors++; $display("FAIL preempt c=%0d got=%b want=%b", c, preempt, epre);
      end
      if (c == 3) emerg = 4'b0100;
      if (c == 60) emerg = 4'b0000;
      tick();
    end
  endtask

  task automatic test_emerg_transit();
    logic [1:0] ep;
    int ed;
    logic epre;
    do_reset(8'b0000_0100);
    for (int c = 1; c <= 40; c++) begin
      if (c <= 15)      begin ep = 2'b00; ed = 0; end
      else if (c <= 20) begin ep = 2'b01; ed = 0; end
      else if (c <= 22) begin ep = 2'b10; ed = 0; end
      else if (c <= 37) begin ep = 2'b00; ed = 0; end
      else              begin ep = 2'b01; ed = 0; end
      epre = (c == 18);
      checks++;
      if (phase !== ep || active_dir !== 2'(ed) || lights !== exp_lamps(ed, ep)) begin
        errors++;
        $display("FAIL transit c=%0d got ph=%b dir=%0d lights=%b want ph=%b dir=%0d lights=%b",
                 c, phase, active_dir, lights, ep, ed, exp_lamps(ed, ep));
      end
      checks++;
      if (preempt !== epre) begin
        errors++; $display("FAIL transit_preempt c=%0d got=%b want=%b", c, preempt, epre);
      end
      if (c == 17) emerg = 4'b0101;
      if (c == 18) emerg = 4'b0000;
      tick();
    end
  endtask

  task automatic test_reset_mid();
    logic [1:0] ep;
    int ed;
    do_reset(8'b0000_0100);
    for (int c = 1; c <= 57; c++) begin
      if (c <= 15)      begin ep = 2'b00; ed = 0; end
      else if (c <= 20) begin ep = 2'b01; ed = 0; end
      else if (c <= 22) begin ep = 2'b10; ed = 0; end
      else if (c <= 37) begin ep = 2'b00; ed = 1; end
      else if (c <= 39) begin ep = 2'b01; ed = 1; end
      else if (c <= 54) begin ep = 2'b00; ed = 0; end
      else              begin ep = 2'b01; ed = 0; end
      checks++;
      if (phase !== ep || active_dir !== 2'(ed) || lights !== exp_lamps(ed, ep)) begin
        errors++;
        $display("FAIL reset_mid c=%0d got ph=%b dir=%0d lights=%b want ph=%b dir=%0d lights=%b",
                 c, phase, active_dir, lights, ep, ed, exp_lamps(ed, ep));
      end
      if (c == 23) sensors = 8'b0000_0101;
      if (c == 39) rst = 1'b1;
      if (c == 40) rst = 1'b0;
      tick();
    end
  endtask

  initial begin
    rst = 1'b1;
    sensors = 8'b0;
    emerg = 4'b0;
    test_reset();
    test_basic();
    test_lane_scaling();
    test_round_robin();
    test_emergency();
    test_emerg_transit();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
